instr_fetch_unit: RTL



---
 rtl/instr_fetch_unit.sv | 109 ++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register and instruction fetch over an Imem req/ack handshake.
// Rev 1.0 -- initial release.
`default_nettype none

module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      PC_src,
  input  logic [XLEN-1:0] Imm_ext,
  input  logic [XLEN-1:0] ALU_result,
  input  logic            Instr_done,
  output logic            Imem_req,
  output logic [XLEN-1:0] Imem_addr,
  input  logic [31:0]     Imem_rdata,
  input  logic            Imem_ack,
  output logic [31:0]     Instr,
  output logic            Instr_valid,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_plus4,
  output logic            Misalign_err
);

  localparam logic [31:0]     NOP    = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [XLEN-1:0] next_pc;
  logic            next_pc_aligned;

  always_comb begin
    next_pc = PC + PC_INC;
    case (PC_src)
      2'b01:   next_pc = PC + Imm_ext;
      2'b10:   next_pc = {ALU_result[XLEN-1:1], 1'b0};
      default: next_pc = PC + PC_INC;
    endcase
    next_pc_aligned = (next_pc[1:0] == 2'b00);
  end

  // Ack takes priority in FETCH simply because Instr_done is only looked at in EXEC.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = FETCH;
      FETCH:   if (Imem_ack) next_state = EXEC;
      EXEC:    if (Instr_done) next_state = next_pc_aligned ? FETCH : ERROR;
      ERROR:   next_state = ERROR;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC           <= RESET_PC;
      Instr        <= NOP;
      Instr_valid  <= 1'b0;
      Misalign_err <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (Imem_ack) begin
            Instr       <= Imem_rdata;
            Instr_valid <= 1'b1;
          end
        end
        EXEC: begin
          if (Instr_done) begin
            Instr_valid <= 1'b0;
            if (next_pc_aligned) begin
              PC <= next_pc;
            end else begin
              Misalign_err <= 1'b1;
            end
          end
        end
        default: begin
          Instr_valid <= 1'b0;
        end
      endcase
    end
  end

  // PC only moves on the edge that enters FETCH, so the address is stable per request.
  assign Imem_req  = (state == FETCH);
  assign Imem_addr = PC;
  assign PC_plus4  = PC + PC_INC;

endmodule

`default_nettype wire
